traffic_cnt_ctrl: RTL and testbench
===================================

// Module: traffic_cnt_ctrl
// PURPOSE
//   Traffic-light phase controller and seconds countdown. It produces the 5-bit
//   count cnt_d consumed by the two-digit 7-segment decoder stage, plus the
//   lamp outputs.
//   Phases cycle RED -> GREEN -> YELLOW -> RED. Each phase counts down from its
//   duration to 1 in one-second steps.
//   cnt_d is never 0, because the display stage blanks that code.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per countdown step (1 s at 50 MHz); must be >= 2
//   T_RED     30          RED duration in steps; legal range 1..31
//   T_GREEN   25          GREEN duration in steps; legal range 1..31
//   T_YELLOW  5           YELLOW duration in steps; legal range 1..31
// PORTS
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   en          in   1  1 = run; 0 = freeze prescaler, count and phase
//   skip        in   1  1-cycle request to end the current phase early
//   cnt_d       out  5  seconds remaining in phase (1..31), to display decoder
//   light       out  3  one-hot lamps {R,Y,G}
//   tick        out  1  1-cycle pulse on every countdown step
//   phase_done  out  1  1-cycle pulse on every phase change
// BEHAVIOUR
//   - Reset (async assert, sync release): state=RED, cnt_d=T_RED, light=3'b100,
//     prescaler=0, tick=0, phase_done=0. Reset mid-phase discards all progress.
//   - All outputs are registered.
//   - Prescaler pre[$clog2(TICK_DIV)-1:0]:
//       - Counts only while en=1; holds its value while en=0.
//       - At pre==TICK_DIV-1 (terminal count, tc) it wraps to 0 on the same edge.
//   - Step edge (tc & en):
//       - tick=1 for exactly the next cycle.
//       - If cnt_d>1: cnt_d <= cnt_d-1, state unchanged.
//       - If cnt_d==1: advance to the next phase, load its duration into cnt_d,
//         phase_done=1 for one cycle.
//   - FSM, 3 states:
//       - RED (light=100) -> GREEN, load T_GREEN.
//       - GREEN (light=001) -> YELLOW, load T_YELLOW.
//       - YELLOW (light=010) -> RED, load T_RED.
//       - light is encoded from state and changes on the same edge as the load.
//   - skip=1 with en=1:
//       - Next edge advances the phase as if cnt_d had reached 1.
//       - Loads the next duration, pulses phase_done, clears pre to 0.
//       - tick is not pulsed.
//   - skip=1 with en=0: ignored.
//   - skip and tc on the same edge: skip wins. Exactly one phase advance and no
//     extra decrement; tick is not pulsed.
//   - en deassert: tick and phase_done are 0 on every edge while en=0.
//     cnt_d, light and pre hold.
//   - Steady-state timing: a phase of duration T lasts exactly T*TICK_DIV cycles.
//     cnt_d shows T, T-1, ..., 1, each for TICK_DIV cycles.
//   - Duration 1: phase shows cnt_d=1 for TICK_DIV cycles, then advances.
//   - cnt_d is 5-bit unsigned. No underflow is possible, because 0 is never
//     loaded or reached.
//   - Illegal state encoding recovers to RED with cnt_d=T_RED on the next edge.
// TESTING
//   (bench uses TICK_DIV=4, T_RED=3, T_GREEN=2, T_YELLOW=1)
//   1. Reset, en=1 for 24 cycles -> cnt_d sequence 3,2,1,2,1,1,3, each value
//      held 4 cycles. light goes 100 -> 001 -> 010 -> 100. phase_done
//      pulses at cycles 12, 20 and 24.
//   2. en=1 for 6 cycles, then en=0 for 10, then en=1 -> no tick while
//      en=0. Next tick arrives 2 cycles after re-enable; cnt_d 2->1.
//   3. skip pulse at cnt_d=3 in RED -> next edge cnt_d=2, light=001,
//      phase_done=1, tick=0, pre=0. GREEN then lasts a full 8 cycles.
//   4. skip asserted on the tc edge with cnt_d=2 in RED -> single advance to
//      GREEN, cnt_d=2 (no decrement to 1 first), tick=0.
//   5. rst asserted asynchronously mid-GREEN (cnt_d=1) -> outputs go to
//      RED/3/100 without waiting for clk. Countdown restarts with a full
//      4-cycle step.
//   6. Assertions throughout: light always one-hot; cnt_d never 0 or
//      above its phase duration; tick and phase_done never high 2
//      consecutive cycles.

Source files
------------

// File: rtl/traffic_cnt_ctrl_if.sv
// Control and display bundle between the traffic controller and its environment:
// run/skip requests in, countdown value, lamps and event pulses out.
interface traffic_cnt_ctrl_if;
    logic       en;
    logic       skip;
    logic [4:0] cnt_d;
    logic [2:0] light;
    logic       tick;
    logic       phase_done;

    modport master (
        output en,
        output skip,
        input  cnt_d,
        input  light,
        input  tick,
        input  phase_done
    );

    modport slave (
        input  en,
        input  skip,
        output cnt_d,
        output light,
        output tick,
        output phase_done
    );
endinterface

// File: rtl/traffic_cnt_ctrl.sv
// Traffic-light phase controller: RED -> GREEN -> YELLOW -> RED, each phase counting
// seconds down from its duration to 1, with early skip and run/freeze control.
module traffic_cnt_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int T_RED    = 30,
    parameter int T_GREEN  = 25,
    parameter int T_YELLOW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_cnt_ctrl_if.slave    io_bus
);

    localparam int             PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_TC = PW'(TICK_DIV - 1);
    localparam logic [4:0]     D_RED  = 5'(T_RED);
    localparam logic [4:0]     D_GRN  = 5'(T_GREEN);
    localparam logic [4:0]     D_YEL  = 5'(T_YELLOW);
    localparam logic [2:0]     L_RED  = 3'b100;
    localparam logic [2:0]     L_GRN  = 3'b001;
    localparam logic [2:0]     L_YEL  = 3'b010;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_pre;
    logic [4:0]      r_cnt;
    logic [2:0]      r_light;
    logic            r_tick;
    logic            r_phase_done;
    logic            w_tc;

    assign w_tc = (r_pre == PRE_TC);

    // Phase FSM, prescaler and countdown; skip overrides a coincident terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RED;
            r_pre        <= '0;
            r_cnt        <= D_RED;
            r_light      <= L_RED;
            r_tick       <= 1'b0;
            r_phase_done <= 1'b0;
        end else begin
            r_tick       <= 1'b0;
            r_phase_done <= 1'b0;
            case (r_state)
                RED, GREEN, YELLOW: begin
                    if (io_bus.en) begin
                        if (io_bus.skip || (w_tc && (r_cnt == 5'd1))) begin
                            r_pre        <= '0;
                            r_phase_done <= 1'b1;
                            r_tick       <= ~io_bus.skip;
                            case (r_state)
                                RED: begin
                                    r_state <= GREEN;
                                    r_cnt   <= D_GRN;
                                    r_light <= L_GRN;
                                end
                                GREEN: begin
                                    r_state <= YELLOW;
                                    r_cnt   <= D_YEL;
                                    r_light <= L_YEL;
                                end
                                default: begin
                                    r_state <= RED;
                                    r_cnt   <= D_RED;
                                    r_light <= L_RED;
                                end
                            endcase
                        end else if (w_tc) begin
                            r_pre  <= '0;
                            r_cnt  <= r_cnt - 5'd1;
                            r_tick <= 1'b1;
                        end else begin
                            r_pre <= r_pre + PW'(1);
                        end
                    end else begin
                        r_pre <= r_pre;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean RED phase
                    r_state <= RED;
                    r_pre   <= '0;
                    r_cnt   <= D_RED;
                    r_light <= L_RED;
                end
            endcase
        end
    end

    assign io_bus.cnt_d      = r_cnt;
    assign io_bus.light      = r_light;
    assign io_bus.tick       = r_tick;
    assign io_bus.phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_cnt_ctrl.sv
// Scoreboard bench for traffic_cnt_ctrl with TICK_DIV=4, T_RED=3, T_GREEN=2, T_YELLOW=1.
// Stimulus pushes hand-computed expected outputs; an independent monitor pops and compares.
module tb_traffic_cnt_ctrl;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;

    typedef struct packed {
        logic [4:0] cnt;
        logic [2:0] light;
        logic       tick;
        logic       pd;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   sample_no;
    exp_t exp_q[$];

    traffic_cnt_ctrl_if bus ();

    traffic_cnt_ctrl #(
        .TICK_DIV (4),
        .T_RED    (3),
        .T_GREEN  (2),
        .T_YELLOW (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given inputs and the outputs expected right after it
    task automatic step(input logic e, input logic s, input logic [4:0] c,
                        input logic [2:0] l, input logic t, input logic pd);
        exp_t x;
        @(negedge clk);
        bus.en   = e;
        bus.skip = s;
        x.cnt = c; x.light = l; x.tick = t; x.pd = pd;
        exp_q.push_back(x);
        @(posedge clk);
    endtask

    // Asynchronous reset 3 time units after an edge; checked before the next clock edge
    task automatic do_reset();
        exp_t x;
        #3;
        bus.en   = 1'b0;
        bus.skip = 1'b0;
        x.cnt = 5'd3; x.light = R; x.tick = 1'b0; x.pd = 1'b0;
        exp_q.push_back(x);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per clock edge or reset assertion and compares
    initial begin
        exp_t e;
        logic prev_tick;
        logic prev_pd;
        logic [4:0] dur;
        prev_tick = 1'b0;
        prev_pd   = 1'b0;
        sample_no = 0;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                sample_no++;
                checks++;
                if (bus.cnt_d !== e.cnt || bus.light !== e.light ||
                    bus.tick !== e.tick || bus.phase_done !== e.pd) begin
                    errors++;
                    $display("FAIL outputs sample %0d: got cnt_d=%0d light=%b tick=%b phase_done=%b, want cnt_d=%0d light=%b tick=%b phase_done=%b",
                             sample_no, bus.cnt_d, bus.light, bus.tick, bus.phase_done,
                             e.cnt, e.light, e.tick, e.pd);
                end
                case (bus.light)
                    R:       dur = 5'd3;
                    G:       dur = 5'd2;
                    Y:       dur = 5'd1;
                    default: dur = 5'd0;
                endcase
                checks++;
                if (dur == 5'd0 || bus.cnt_d == 5'd0 || bus.cnt_d > dur ||
                    (prev_tick && bus.tick) || (prev_pd && bus.phase_done)) begin
                    errors++;
                    $display("FAIL invariant sample %0d: light=%b cnt_d=%0d tick=%b(prev %b) phase_done=%b(prev %b), want one-hot light, 1<=cnt_d<=duration, no back-to-back pulses",
                             sample_no, bus.light, bus.cnt_d, bus.tick, prev_tick,
                             bus.phase_done, prev_pd);
                end
                prev_tick = bus.tick;
                prev_pd   = bus.phase_done;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish before limit");
        $fatal(1, "watchdog");
    end

    logic [4:0] t1_hold [6] = '{5'd3, 5'd2, 5'd1, 5'd2, 5'd1, 5'd1};
    logic [2:0] t1_hl   [6] = '{R, R, R, G, G, Y};
    logic [4:0] t1_next [6] = '{5'd2, 5'd1, 5'd2, 5'd1, 5'd1, 5'd3};
    logic [2:0] t1_nl   [6] = '{R, R, G, G, Y, R};
    logic       t1_pd   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.skip = 1'b0;

        // Reset state
        do_reset();

        // Full cycle: 3,2,1 RED; 2,1 GREEN; 1 YELLOW; back to 3 RED
        for (int g = 0; g < 6; g++) begin
            repeat (3) step(1'b1, 1'b0, t1_hold[g], t1_hl[g], 1'b0, 1'b0);
            step(1'b1, 1'b0, t1_next[g], t1_nl[g], 1'b1, t1_pd[g]);
        end

        // Freeze: 6 running edges, 10 frozen (one with skip, ignored), then resume
        repeat (3) step(1'b1, 1'b0, 5'd3, R, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd2, R, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b0, 5'd2, R, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, (i == 4), 5'd2, R, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd2, R, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd1, R, 1'b1, 1'b0);

        // Skip at cnt_d=3 in RED, then GREEN lasts a full 8 cycles
        do_reset();
        step(1'b1, 1'b0, 5'd3, R, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd2, G, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 5'd2, G, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd1, G, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 5'd1, G, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd1, Y, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 5'd1, Y, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd3, R, 1'b1, 1'b1);

        // Skip coinciding with terminal count at cnt_d=2: one advance, no decrement
        repeat (3) step(1'b1, 1'b0, 5'd3, R, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd2, R, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 5'd2, R, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd2, G, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 5'd2, G, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd1, G, 1'b1, 1'b0);
        step(1'b1, 1'b0, 5'd1, G, 1'b0, 1'b0);

        // Asynchronous reset mid-GREEN, then a full 4-cycle first step
        do_reset();
        repeat (3) step(1'b1, 1'b0, 5'd3, R, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd2, R, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
